// File: rtl/cfg_layer_seq.sv
// rtl/cfg_layer_seq.sv - per-layer configuration table with start/lay_done layer sequencer
module cfg_layer_seq #(
  parameter int LENROW_W   = 5,
  parameter int BLK_W      = 6,
  parameter int FRM_W      = 4,
  parameter int PAT_W      = 4,
  parameter int LAY_W      = 4,
  parameter int DEPTH      = 8,
  parameter int DEF_LENROW = 16,
  parameter int DEF_DEPBLK = 32,
  parameter int DEF_NUMBLK = 2,
  parameter int DEF_NUMFRM = 8,
  parameter int DEF_NUMPAT = 1,
  parameter int DEF_NUMLAY = 8,
  localparam int E = LENROW_W + 2*BLK_W + FRM_W + PAT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                wr_vld,
  output logic                wr_rdy,
  input  logic [E-1:0]        wr_data,
  input  logic                wr_last,
  input  logic                start,
  input  logic                lay_done,
  output logic [LENROW_W-1:0] CFG_LenRow,
  output logic [BLK_W-1:0]    CFG_DepBlk,
  output logic [BLK_W-1:0]    CFG_NumBlk,
  output logic [FRM_W-1:0]    CFG_NumFrm,
  output logic [PAT_W-1:0]    CFG_NumPat,
  output logic [LAY_W-1:0]    CFG_NumLay,
  output logic [LAY_W-1:0]    CFG_LayIdx,
  output logic                cfg_vld,
  output logic                busy,
  output logic                all_done
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0]    LAST_PTR = PW'(DEPTH - 1);
  localparam logic [PW-1:0]    PTR_ONE  = PW'(1);
  localparam logic [LAY_W-1:0] LAY_ONE  = LAY_W'(1);

  typedef enum logic [2:0] {IDLE, LOAD, READY, APPLY, RUN} state_t;

  state_t        state_q, state_d;
  logic [E-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [E-1:0]  rd_entry;
  logic          wr_acc;
  logic          last_lay;

  assign wr_acc   = wr_vld & wr_rdy;
  assign last_lay = (CFG_LayIdx == CFG_NumLay - LAY_ONE);
  assign rd_entry = mem[CFG_LayIdx[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = (state_q == APPLY) || (state_q == RUN);
    if (clr) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (wr_acc) state_d = wr_last ? READY : LOAD;
        LOAD:    if (wr_acc && (wr_last || wr_ptr == LAST_PTR)) state_d = READY;
        READY:   if (start) state_d = APPLY;
        APPLY:   state_d = RUN;
        RUN:     if (lay_done) state_d = last_lay ? READY : APPLY;
        default: state_d = IDLE;
      endcase
    end
  end

  // Table storage carries no reset; entries are only read after being written.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_rdy     <= 1'b1;
      wr_ptr     <= '0;
      cfg_vld    <= 1'b0;
      all_done   <= 1'b0;
      CFG_LayIdx <= '0;
      CFG_LenRow <= LENROW_W'(DEF_LENROW);
      CFG_DepBlk <= BLK_W'(DEF_DEPBLK);
      CFG_NumBlk <= BLK_W'(DEF_NUMBLK);
      CFG_NumFrm <= FRM_W'(DEF_NUMFRM);
      CFG_NumPat <= PAT_W'(DEF_NUMPAT);
      CFG_NumLay <= LAY_W'(DEF_NUMLAY);
    end else if (clr) begin
      wr_rdy     <= 1'b1;
      wr_ptr     <= '0;
      cfg_vld    <= 1'b0;
      all_done   <= 1'b0;
      CFG_LayIdx <= '0;
      CFG_LenRow <= LENROW_W'(DEF_LENROW);
      CFG_DepBlk <= BLK_W'(DEF_DEPBLK);
      CFG_NumBlk <= BLK_W'(DEF_NUMBLK);
      CFG_NumFrm <= FRM_W'(DEF_NUMFRM);
      CFG_NumPat <= PAT_W'(DEF_NUMPAT);
      CFG_NumLay <= LAY_W'(DEF_NUMLAY);
    end else begin
      // Ready is looked ahead from the next state so it stays a pure register.
      wr_rdy   <= (state_d == IDLE) || (state_d == LOAD);
      all_done <= 1'b0;
      case (state_q)
        IDLE, LOAD: begin
          if (wr_acc) begin
            wr_ptr <= wr_ptr + PTR_ONE;
            if (state_d == READY) CFG_NumLay <= LAY_W'(wr_ptr) + LAY_ONE;
          end
        end
        READY: begin
          if (start) CFG_LayIdx <= '0;
        end
        APPLY: begin
          CFG_LenRow <= rd_entry[E-1 -: LENROW_W];
          CFG_DepBlk <= rd_entry[E-LENROW_W-1 -: BLK_W];
          CFG_NumBlk <= rd_entry[FRM_W+PAT_W+BLK_W-1 -: BLK_W];
          CFG_NumFrm <= rd_entry[PAT_W+FRM_W-1 -: FRM_W];
          CFG_NumPat <= rd_entry[PAT_W-1:0];
          cfg_vld    <= 1'b1;
        end
        RUN: begin
          if (lay_done) begin
            cfg_vld <= 1'b0;
            if (last_lay) all_done   <= 1'b1;
            else          CFG_LayIdx <= CFG_LayIdx + LAY_ONE;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cfg_layer_seq.sv
// tb/tb_cfg_layer_seq.sv - table-driven directed bench for cfg_layer_seq
module tb_cfg_layer_seq;
  localparam int E = 25;

  logic clk = 1'b0, rst_n = 1'b1, clr = 1'b0;
  logic wr_vld = 1'b0, wr_last = 1'b0, start = 1'b0, lay_done = 1'b0;
  logic [E-1:0] wr_data = '0;
  logic wr_rdy, cfg_vld, busy, all_done;
  logic [4:0] CFG_LenRow;
  logic [5:0] CFG_DepBlk, CFG_NumBlk;
  logic [3:0] CFG_NumFrm, CFG_NumPat, CFG_NumLay, CFG_LayIdx;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cfg_layer_seq dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .wr_vld(wr_vld), .wr_rdy(wr_rdy), .wr_data(wr_data), .wr_last(wr_last),
    .start(start), .lay_done(lay_done),
    .CFG_LenRow(CFG_LenRow), .CFG_DepBlk(CFG_DepBlk), .CFG_NumBlk(CFG_NumBlk),
    .CFG_NumFrm(CFG_NumFrm), .CFG_NumPat(CFG_NumPat), .CFG_NumLay(CFG_NumLay),
    .CFG_LayIdx(CFG_LayIdx), .cfg_vld(cfg_vld), .busy(busy), .all_done(all_done)
  );

  typedef struct {
    logic         vld, last;
    logic [E-1:0] data;
    logic         st, ld, cl;
    logic [E-1:0] e_cfg;
    logic [3:0]   e_nlay, e_idx;
    logic         e_cv, e_ad, e_rdy, e_busy;
  } vec_t;

  vec_t vq[$];

  function automatic logic [E-1:0] pk(input int len, dep, num, frm, pat);
    return {5'(len), 6'(dep), 6'(num), 4'(frm), 4'(pat)};
  endfunction

  function automatic logic [E-1:0] fe(input int k);
    return pk(k, k + 40, k + 1, k, 15 - k);
  endfunction

  task automatic add(input logic vld, last, input logic [E-1:0] data, input logic st, ld, cl,
                     input logic [E-1:0] ecfg, input int nlay, idx, input logic cv, ad, rdy, bsy);
    vec_t v;
    v.vld = vld; v.last = last; v.data = data; v.st = st; v.ld = ld; v.cl = cl;
    v.e_cfg = ecfg; v.e_nlay = 4'(nlay); v.e_idx = 4'(idx);
    v.e_cv = cv; v.e_ad = ad; v.e_rdy = rdy; v.e_busy = bsy;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input int i, input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %0h want %0h", nm, i, act, exp);
    end
  endtask

  task automatic check_outs(input int i, input logic [E-1:0] ecfg, input logic [3:0] nlay, idx,
                            input logic cv, ad, rdy, bsy);
    chk("cfg", i, 32'({CFG_LenRow, CFG_DepBlk, CFG_NumBlk, CFG_NumFrm, CFG_NumPat}), 32'(ecfg));
    chk("num_lay", i, 32'(CFG_NumLay), 32'(nlay));
    chk("lay_idx", i, 32'(CFG_LayIdx), 32'(idx));
    chk("cfg_vld", i, 32'(cfg_vld), 32'(cv));
    chk("all_done", i, 32'(all_done), 32'(ad));
    chk("wr_rdy", i, 32'(wr_rdy), 32'(rdy));
    chk("busy", i, 32'(busy), 32'(bsy));
  endtask

  initial begin
    logic [E-1:0] df, a0, a1, a2, sx, junk;
    df   = pk(16, 32, 2, 8, 1);
    a0   = pk(3, 10, 1, 2, 1);
    a1   = pk(7, 20, 3, 4, 2);
    a2   = pk(31, 63, 63, 15, 15);
    sx   = pk(9, 5, 17, 6, 3);
    junk = pk(1, 1, 1, 1, 1);

    // three-entry load with gaps, then run
    add(1,0,a0,  0,0,0, df,8,0,0,0,1,0);
    add(0,0,a1,  0,0,0, df,8,0,0,0,1,0);
    add(1,0,a1,  0,0,0, df,8,0,0,0,1,0);
    add(0,0,'0,  0,0,0, df,8,0,0,0,1,0);
    add(1,1,a2,  0,0,0, df,3,0,0,0,0,0);
    add(1,1,junk,0,0,0, df,3,0,0,0,0,0);
    add(0,0,'0,  1,0,0, df,3,0,0,0,0,1);
    add(0,0,'0,  0,0,0, a0,3,0,1,0,0,1);
    add(0,0,'0,  0,0,0, a0,3,0,1,0,0,1);
    add(0,0,'0,  0,1,0, a0,3,1,0,0,0,1);
    add(0,0,'0,  0,0,0, a1,3,1,1,0,0,1);
    add(0,0,'0,  0,1,0, a1,3,2,0,0,0,1);
    add(0,0,'0,  0,0,0, a2,3,2,1,0,0,1);
    add(0,0,'0,  0,1,0, a2,3,2,0,1,0,0);
    add(0,0,'0,  0,0,0, a2,3,2,0,0,0,0);
    // ignored inputs: lay_done in READY, start in APPLY/RUN
    add(0,0,'0,  0,1,0, a2,3,2,0,0,0,0);
    add(0,0,'0,  1,0,0, a2,3,0,0,0,0,1);
    add(0,0,'0,  1,0,0, a0,3,0,1,0,0,1);
    add(0,0,'0,  1,0,0, a0,3,0,1,0,0,1);
    add(0,0,'0,  0,1,0, a0,3,1,0,0,0,1);
    add(0,0,'0,  0,0,0, a1,3,1,1,0,0,1);
    // clr coincident with lay_done at layer 1
    add(0,0,'0,  0,1,1, df,8,0,0,0,1,0);
    add(0,0,'0,  0,0,0, df,8,0,0,0,1,0);
    // full table without wr_last, then a refused 9th beat
    for (int k = 0; k < 8; k++) add(1,0,fe(k),0,0,0, df,8,0,0,0,(k < 7),0);
    add(1,0,junk,0,0,0, df,8,0,0,0,0,0);
    add(0,0,'0,  1,0,0, df,8,0,0,0,0,1);
    for (int k = 0; k < 8; k++) begin
      add(0,0,'0,0,0,0, fe(k),8,k,1,0,0,1);
      if (k < 7) add(0,0,'0,0,1,0, fe(k),8,k+1,0,0,0,1);
      else       add(0,0,'0,0,1,0, fe(k),8,k,0,1,0,0);
    end
    add(0,0,'0,  0,0,1, df,8,0,0,0,1,0);
    // single entry, run twice
    add(1,1,sx,  0,0,0, df,1,0,0,0,0,0);
    add(0,0,'0,  1,0,0, df,1,0,0,0,0,1);
    add(0,0,'0,  0,0,0, sx,1,0,1,0,0,1);
    add(0,0,'0,  0,1,0, sx,1,0,0,1,0,0);
    add(0,0,'0,  0,0,0, sx,1,0,0,0,0,0);
    add(0,0,'0,  1,0,0, sx,1,0,0,0,0,1);
    add(0,0,'0,  0,0,0, sx,1,0,1,0,0,1);
    add(0,0,'0,  0,1,0, sx,1,0,0,1,0,0);
    add(0,0,'0,  0,0,0, sx,1,0,0,0,0,0);

    // reset state
    #1 rst_n = 1'b0;
    #1 check_outs(-1, df, 8, 0, 0, 0, 1, 0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      wr_vld = vq[i].vld; wr_last = vq[i].last; wr_data = vq[i].data;
      start = vq[i].st; lay_done = vq[i].ld; clr = vq[i].cl;
      @(posedge clk);
      #1 check_outs(i, vq[i].e_cfg, vq[i].e_nlay, vq[i].e_idx,
                    vq[i].e_cv, vq[i].e_ad, vq[i].e_rdy, vq[i].e_busy);
    end

    // async reset while RUN with the single-entry table
    @(negedge clk);
    wr_vld = 1'b0; wr_last = 1'b0; lay_done = 1'b0; clr = 1'b0; start = 1'b1;
    @(negedge clk) start = 1'b0;
    @(negedge clk);
    check_outs(1000, sx, 1, 0, 1, 0, 0, 1);
    #2 rst_n = 1'b0;
    #1 check_outs(1001, df, 8, 0, 0, 0, 1, 0);
    @(negedge clk);
    rst_n = 1'b1; lay_done = 1'b1;
    @(posedge clk);
    #1 check_outs(1002, df, 8, 0, 0, 0, 1, 0);
    @(negedge clk) lay_done = 1'b0;
    @(posedge clk);
    #1 check_outs(1003, df, 8, 0, 0, 0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
